// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states and port IDs.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MCU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_MCU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_t;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port (MCU, DMA) arbiter for a single synchronous RAM; no port is granted twice in a row.
// Define RAM_ARB_RR_EN to break ties round-robin; otherwise ties always go to the MCU.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mcu_req,
    input  logic                  mcu_write,
    input  logic [ADDR_WIDTH-1:0] mcu_addr,
    input  logic [DATA_WIDTH-1:0] mcu_wdata,
    input  logic                  dma_req,
    input  logic                  dma_write,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  mcu_gnt,
    output logic                  dma_gnt,
    output logic                  mcu_rvalid,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] mcu_rdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mcu_stall,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    arb_state_t            state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mcu_elig, dma_elig;
`ifdef RAM_ARB_RR_EN
    port_id_t              last_grant;
`endif

    // The port holding the grant this cycle sits out the next decision.
    assign mcu_elig = mcu_req && (state != ARB_MCU);
    assign dma_elig = dma_req && (state != ARB_DMA);

    always_comb begin
        next_state = ARB_IDLE;
        if (mcu_elig && dma_elig) begin
`ifdef RAM_ARB_RR_EN
            next_state = (last_grant == PORT_MCU) ? ARB_DMA : ARB_MCU;
`else
            next_state = ARB_MCU;
`endif
        end else if (mcu_elig) begin
            next_state = ARB_MCU;
        end else if (dma_elig) begin
            next_state = ARB_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            mcu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef RAM_ARB_RR_EN
            last_grant <= PORT_DMA;
`endif
        end else begin
            state      <= next_state;
            mcu_rvalid <= (state == ARB_MCU) && !mcu_write;
            dma_rvalid <= (state == ARB_DMA) && !dma_write;
            if (state != ARB_IDLE) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
            end
`ifdef RAM_ARB_RR_EN
            if (state == ARB_MCU) last_grant <= PORT_MCU;
            else if (state == ARB_DMA) last_grant <= PORT_DMA;
`endif
        end
    end

    // RAM command follows the granted port; idle keeps the last address/data on the bus.
    always_comb begin
        ram_write = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        case (state)
            ARB_MCU: begin
                ram_write = mcu_write;
                ram_addr  = mcu_addr;
                ram_wdata = mcu_wdata;
            end
            ARB_DMA: begin
                ram_write = dma_write;
                ram_addr  = dma_addr;
                ram_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    assign mcu_gnt   = (state == ARB_MCU);
    assign dma_gnt   = (state == ARB_DMA);
    assign mcu_rdata = ram_rdata;
    assign dma_rdata = ram_rdata;
    assign mcu_stall = mcu_req && !mcu_gnt;
    assign busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a grant/memory reference model.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       mcu_req, mcu_write, dma_req, dma_write;
    logic [7:0] mcu_addr, mcu_wdata, dma_addr, dma_wdata;
    logic       mcu_gnt, dma_gnt, mcu_rvalid, dma_rvalid, mcu_stall, ram_write, busy;
    logic [7:0] mcu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;

    logic [7:0] mem [256];
    logic [7:0] mm  [256];

    int total = 0;
    int bad   = 0;

    // reference model: 0 = nobody granted, 1 = MCU, 2 = DMA
    int         g, last, tick_g;
    logic [7:0] held_addr, held_wdata, exp_rdata;
    logic       exp_mrv, exp_drv;

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .mcu_req(mcu_req), .mcu_write(mcu_write), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .mcu_gnt(mcu_gnt), .dma_gnt(dma_gnt), .mcu_rvalid(mcu_rvalid), .dma_rvalid(dma_rvalid),
        .mcu_rdata(mcu_rdata), .dma_rdata(dma_rdata), .mcu_stall(mcu_stall),
        .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // synchronous RAM attached to the arbiter
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dut_g();
        return mcu_gnt ? 1 : (dma_gnt ? 2 : 0);
    endfunction

    task automatic model_reset();
        g = 0; last = 2; held_addr = 8'h00; held_wdata = 8'h00;
        exp_mrv = 1'b0; exp_drv = 1'b0;
    endtask

    // Check the current cycle at the falling edge, advance the model, move to the next cycle.
    task automatic tick();
        logic       erw, em, ed;
        logic [7:0] ea, ew;
        int         ng;
        @(negedge clk);
        erw = (g == 1) ? mcu_write : (g == 2) ? dma_write : 1'b0;
        ea  = (g == 1) ? mcu_addr  : (g == 2) ? dma_addr  : held_addr;
        ew  = (g == 1) ? mcu_wdata : (g == 2) ? dma_wdata : held_wdata;
        chk("mcu_gnt", mcu_gnt, g == 1);
        chk("dma_gnt", dma_gnt, g == 2);
        chk("busy", busy, g != 0);
        chk("ram_write", ram_write, erw);
        chk("ram_addr", ram_addr, ea);
        chk("ram_wdata", ram_wdata, ew);
        chk("mcu_stall", mcu_stall, mcu_req && (g != 1));
        chk("mcu_rvalid", mcu_rvalid, exp_mrv);
        chk("dma_rvalid", dma_rvalid, exp_drv);
        if (exp_mrv) chk("mcu_rdata", mcu_rdata, exp_rdata);
        if (exp_drv) chk("dma_rdata", dma_rdata, exp_rdata);
        tick_g = g;
        exp_mrv = (g == 1) && !mcu_write;
        exp_drv = (g == 2) && !dma_write;
        if (g != 0) begin
            if (erw) mm[ea] = ew;
            else exp_rdata = mm[ea];
            held_addr = ea; held_wdata = ew; last = g;
        end
        em = mcu_req && (g != 1);
        ed = dma_req && (g != 2);
        if (em && ed) begin
`ifdef RAM_ARB_RR_EN
            ng = (last == 1) ? 2 : 1;
`else
            ng = 1;
`endif
        end else if (em) ng = 1;
        else if (ed) ng = 2;
        else ng = 0;
        g = ng;
        if (rst) model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  seq [5];
        int  exp_seq [5];
        int  cnt;
        bit  m_act, d_act;
        exp_seq = '{1, 2, 1, 2, 1};
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 7 + 3);
            mm[i]  = 8'(i * 7 + 3);
        end
        mem[8'h10] = 8'h5A; mm[8'h10] = 8'h5A;
        rst = 1'b1;
        mcu_req = 0; mcu_write = 0; mcu_addr = 0; mcu_wdata = 0;
        dma_req = 0; dma_write = 0; dma_addr = 0; dma_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        chk("rst_busy", busy, 0);
        chk("rst_addr", ram_addr, 8'h00);
        chk("rst_rvalid", mcu_rvalid, 0);
        tick();

        // both request from idle: MCU first, then DMA; MCU stalls meanwhile
        mcu_req = 1; mcu_write = 0; mcu_addr = 8'h20;
        dma_req = 1; dma_write = 0; dma_addr = 8'h21;
        #1 chk("both_stall_c0", mcu_stall, 1);
        tick();
        chk("both_mcu_c1", mcu_gnt, 1);
        chk("both_dma_c1", dma_gnt, 0);
        tick();
        mcu_req = 0;
        chk("both_dma_c2", dma_gnt, 1);
        tick();
        dma_req = 0;
        tick(); tick();

        // single MCU read of the preloaded word
        mcu_req = 1; mcu_write = 0; mcu_addr = 8'h10;
        tick();
        chk("rd_gnt_c1", mcu_gnt, 1);
        chk("rd_addr_c1", ram_addr, 8'h10);
        tick();
        mcu_req = 0;
        chk("rd_rvalid_c2", mcu_rvalid, 1);
        chk("rd_rdata_c2", mcu_rdata, 8'h5A);
        tick(); tick();

        // both held for 6 cycles after reset: strict alternation
        rst = 1; tick(); rst = 0;
        mcu_req = 1; mcu_addr = 8'h30; dma_req = 1; dma_addr = 8'h31;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 5) seq[k] = dut_g();
        end
        mcu_req = 0; dma_req = 0;
        for (int k = 0; k < 5; k++) chk("alt_seq", seq[k], exp_seq[k]);
        tick(); tick(); tick();

        // DMA write
        dma_req = 1; dma_write = 1; dma_addr = 8'h3F; dma_wdata = 8'hA5;
        tick();
        chk("wr_gnt", dma_gnt, 1);
        chk("wr_we", ram_write, 1);
        chk("wr_addr", ram_addr, 8'h3F);
        chk("wr_data", ram_wdata, 8'hA5);
        tick();
        dma_req = 0; dma_write = 0;
        chk("wr_we_off", ram_write, 0);
        chk("wr_no_rvalid", dma_rvalid, 0);
        tick();
        chk("wr_mem", mem[8'h3F], 8'hA5);
        chk("wr_no_rvalid2", dma_rvalid, 0);
        tick();

        // reset during an MCU read grant
        mcu_req = 1; mcu_write = 0; mcu_addr = 8'h55;
        tick();
        rst = 1;
        chk("rr_gnt", mcu_gnt, 1);
        tick();
        rst = 0; mcu_req = 0;
        chk("rr_busy", busy, 0);
        chk("rr_rvalid", mcu_rvalid, 0);
        chk("rr_we", ram_write, 0);
        chk("rr_addr", ram_addr, 8'h00);
        tick(); tick();

        // one-cycle request pulse still completes exactly once
        mcu_req = 1; mcu_write = 0; mcu_addr = 8'h44;
        tick();
        mcu_req = 0;
        chk("pulse_gnt", mcu_gnt, 1);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mcu_gnt) cnt++;
        end
        chk("pulse_one_grant", cnt, 0);

        // random traffic; requesters hold until granted
        m_act = 0; d_act = 0;
        for (int n = 0; n < 500; n++) begin
            if (!m_act && ($urandom % 3 == 0)) begin
                m_act = 1; mcu_write = 1'($urandom); mcu_addr = 8'($urandom_range(0, 31));
                mcu_wdata = 8'($urandom);
            end
            if (!d_act && ($urandom % 3 == 0)) begin
                d_act = 1; dma_write = 1'($urandom); dma_addr = 8'($urandom_range(0, 31));
                dma_wdata = 8'($urandom);
            end
            mcu_req = m_act; dma_req = d_act;
            rst = ($urandom % 60 == 0);
            tick();
            if (tick_g == 1) m_act = 0;
            if (tick_g == 2) d_act = 0;
        end
        rst = 0; mcu_req = 0; dma_req = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
